// File: rtl/id_operand_scoreboard.sv
// ---------------------------------------------------------------------------
// id_operand_scoreboard
//   Operand resolution for the ID stage. For each of NUM_SRC read ports it
//   chooses between the regfile data and the nearest of NUM_FWD forwarding
//   stages (index 0 = EXE, nearest). It stalls ID on a load-use hazard, on a
//   RAW against an in-flight long-latency op, and on a WAW against one. A busy
//   bit per register tracks the in-flight long ops. A saturating counter
//   counts the cycles in which ID is held.
//
// Ports
//   clk, reset      clock and synchronous active-high reset
//   id_valid        ID holds a valid instruction
//   src_valid       per-port "operand is actually read"
//   src_raddr       per-port read address (port i at [i*ADDR_W +: ADDR_W])
//   rf_rdata        per-port regfile read data
//   dst_we/dst_addr destination of the instruction in ID
//   fwd_*           per-stage valid / write-enable / address / data / data_ok
//   lat_issue       long op leaves ID this cycle, marks dst_addr busy
//   lat_done        long op completes, clears lat_done_waddr
//   flush           aborts all in-flight long ops
//   cnt_clr         clears the stall counter
//   src_value       resolved operand per port (combinational)
//   id_ready_go     ID may advance (combinational)
//   busy_vec        scoreboard busy bits (registered, bit 0 always 0)
//   stall_cnt       saturating stall-cycle count (registered)
// ---------------------------------------------------------------------------
module id_operand_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*ADDR_W-1:0]   src_raddr,
    input  logic [NUM_SRC*DATA_W-1:0]   rf_rdata,
    input  logic                        dst_we,
    input  logic [ADDR_W-1:0]           dst_addr,
    input  logic [NUM_FWD-1:0]          fwd_valid,
    input  logic [NUM_FWD-1:0]          fwd_we,
    input  logic [NUM_FWD*ADDR_W-1:0]   fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
    input  logic [NUM_FWD-1:0]          fwd_data_ok,
    input  logic                        lat_issue,
    input  logic                        lat_done,
    input  logic [ADDR_W-1:0]           lat_done_waddr,
    input  logic                        flush,
    input  logic                        cnt_clr,
    output logic [NUM_SRC*DATA_W-1:0]   src_value,
    output logic                        id_ready_go,
    output logic [2**ADDR_W-1:0]        busy_vec,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int REG_NUM = 2**ADDR_W;

    logic [REG_NUM-1:0]  busy_r;
    logic [REG_NUM-1:0]  busy_nxt_s;
    logic [CNT_W-1:0]    stall_cnt_r;
    logic [NUM_SRC-1:0]  port_stall_s;
    logic                waw_stall_s;
    logic                ready_go_s;
    logic                hit_found_s;
    logic                hit_ok_s;
    logic [DATA_W-1:0]   hit_data_s;

    // Per-port operand select (nearest forwarding hit wins) and RAW stall detect.
    always_comb begin
        src_value    = '0;
        port_stall_s = '0;
        hit_found_s  = 1'b0;
        hit_ok_s     = 1'b1;
        hit_data_s   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hit_found_s = 1'b0;
            hit_ok_s    = 1'b1;
            hit_data_s  = rf_rdata[i*DATA_W +: DATA_W];
            for (int j = 0; j < NUM_FWD; j++) begin
                // Once the nearest match is found, farther stages are ignored
                // even if their data is final: they hold an older value.
                if (!hit_found_s && fwd_valid[j] && fwd_we[j] &&
                    (fwd_waddr[j*ADDR_W +: ADDR_W] == src_raddr[i*ADDR_W +: ADDR_W]) &&
                    (src_raddr[i*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}})) begin
                    hit_found_s = 1'b1;
                    hit_ok_s    = fwd_data_ok[j];
                    hit_data_s  = fwd_wdata[j*DATA_W +: DATA_W];
                end else begin
                    hit_found_s = hit_found_s;
                end
            end
            src_value[i*DATA_W +: DATA_W] = hit_data_s;
            // Busy is the pre-update value: the cycle lat_done fires still stalls.
            if (id_valid && src_valid[i] &&
                ((hit_found_s && !hit_ok_s) || busy_r[src_raddr[i*ADDR_W +: ADDR_W]])) begin
                port_stall_s[i] = 1'b1;
            end else begin
                port_stall_s[i] = 1'b0;
            end
        end
    end

    // WAW stall and the overall go signal; independent of lat_issue by design.
    always_comb begin
        waw_stall_s = id_valid && dst_we && (dst_addr != {ADDR_W{1'b0}}) && busy_r[dst_addr];
        ready_go_s  = !((|port_stall_s) || waw_stall_s);
    end

    // Next busy vector: clear on completion first, so a same-cycle issue wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (lat_done) begin
            busy_nxt_s[lat_done_waddr] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (lat_issue && (dst_addr != {ADDR_W{1'b0}})) begin
            busy_nxt_s[dst_addr] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard register; flush aborts every in-flight long op.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Saturating stall-cycle counter; clear has priority, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (cnt_clr) begin
            stall_cnt_r <= '0;
        end else if (id_valid && !ready_go_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign id_ready_go = ready_go_s;
    assign busy_vec    = busy_r;
    assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_operand_scoreboard
//   Directed bench. Each stimulus cycle queues the values the outputs must
//   show in that cycle; a monitor on the falling edge drains the queue and
//   compares against the DUT. A second instance with a 4-bit counter covers
//   counter saturation and clear.
// ---------------------------------------------------------------------------
module tb_id_operand_scoreboard;

    localparam int NS = 2;
    localparam int NF = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [NS-1:0]     src_valid;
    logic [NS*AW-1:0]  src_raddr;
    logic [NS*DW-1:0]  rf_rdata;
    logic              dst_we;
    logic [AW-1:0]     dst_addr;
    logic [NF-1:0]     fwd_valid;
    logic [NF-1:0]     fwd_we;
    logic [NF*AW-1:0]  fwd_waddr;
    logic [NF*DW-1:0]  fwd_wdata;
    logic [NF-1:0]     fwd_data_ok;
    logic              lat_issue;
    logic              lat_done;
    logic [AW-1:0]     lat_done_waddr;
    logic              flush;
    logic              cnt_clr;
    logic [NS*DW-1:0]  src_value;
    logic              id_ready_go;
    logic [31:0]       busy_vec;
    logic [31:0]       stall_cnt;

    // small-counter instance: permanent load-use stall on r1
    logic              s_cnt_clr;
    logic [NS*DW-1:0]  s_src_value;
    logic              s_ready_go;
    logic [31:0]       s_busy_vec;
    logic [3:0]        s_stall_cnt;
    logic [NS*AW-1:0]  s_raddr;
    logic [NS*DW-1:0]  s_rf;
    logic [NF*AW-1:0]  s_fwaddr;
    logic [NF*DW-1:0]  s_fwdata;

    logic              done_r = 1'b0;

    always #5 clk = ~clk;

    id_operand_scoreboard #(.NUM_SRC(NS), .NUM_FWD(NF), .ADDR_W(AW), .DATA_W(DW), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .src_valid(src_valid),
        .src_raddr(src_raddr), .rf_rdata(rf_rdata), .dst_we(dst_we), .dst_addr(dst_addr),
        .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .fwd_data_ok(fwd_data_ok), .lat_issue(lat_issue), .lat_done(lat_done),
        .lat_done_waddr(lat_done_waddr), .flush(flush), .cnt_clr(cnt_clr),
        .src_value(src_value), .id_ready_go(id_ready_go), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    id_operand_scoreboard #(.NUM_SRC(NS), .NUM_FWD(NF), .ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .id_valid(1'b1), .src_valid(2'b01),
        .src_raddr(s_raddr), .rf_rdata(s_rf), .dst_we(1'b0), .dst_addr(5'd0),
        .fwd_valid(3'b001), .fwd_we(3'b001), .fwd_waddr(s_fwaddr), .fwd_wdata(s_fwdata),
        .fwd_data_ok(3'b000), .lat_issue(1'b0), .lat_done(1'b0),
        .lat_done_waddr(5'd0), .flush(1'b0), .cnt_clr(s_cnt_clr),
        .src_value(s_src_value), .id_ready_go(s_ready_go), .busy_vec(s_busy_vec), .stall_cnt(s_stall_cnt)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        q[$];
    chk_t        c;
    logic [31:0] act;
    int          n_total = 0;
    int          n_pass  = 0;

    localparam int S_SRC0 = 0, S_SRC1 = 1, S_GO = 2, S_BUSY = 3, S_CNT = 4,
                   S_SCNT = 5, S_SGO = 6, S_SSRC0 = 7, S_SBUSY = 8;

    function automatic void expect_val(input string name, input int sel, input logic [31:0] exp);
        chk_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        q.push_back(e);
    endfunction

    // monitor: outputs are sampled on the falling edge, away from the update edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            c = q.pop_front();
            case (c.sel)
                S_SRC0:  act = src_value[31:0];
                S_SRC1:  act = src_value[63:32];
                S_GO:    act = {31'd0, id_ready_go};
                S_BUSY:  act = busy_vec;
                S_CNT:   act = stall_cnt;
                S_SCNT:  act = {28'd0, s_stall_cnt};
                S_SGO:   act = {31'd0, s_ready_go};
                S_SSRC0: act = s_src_value[31:0];
                S_SBUSY: act = s_busy_vec;
                default: act = 32'hxxxx_xxxx;
            endcase
            n_total++;
            if (act === c.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    // watchdog: the directed sequence must finish within a bounded time
    initial begin
        #100000;
        if (!done_r) begin
            $display("FAIL timeout: directed sequence did not complete");
            $finish;
        end else begin
            done_r = done_r;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        id_valid = 1'b0; src_valid = '0; src_raddr = '0; rf_rdata = '0;
        dst_we = 1'b0; dst_addr = '0;
        fwd_valid = '0; fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_data_ok = '0;
        lat_issue = 1'b0; lat_done = 1'b0; lat_done_waddr = '0; flush = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic set_fwd(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ok);
        fwd_valid[j] = 1'b1;
        fwd_we[j]    = 1'b1;
        fwd_waddr[j*AW +: AW] = a;
        fwd_wdata[j*DW +: DW] = d;
        fwd_data_ok[j] = ok;
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        id_valid = 1'b1;
        src_valid[i] = 1'b1;
        src_raddr[i*AW +: AW] = a;
        rf_rdata[i*DW +: DW]  = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_cnt_clr = 1'b0;
        s_raddr   = {5'd0, 5'd1};
        s_rf      = {32'h0, 32'h0000_0abc};
        s_fwaddr  = {5'd0, 5'd0, 5'd1};
        s_fwdata  = {32'h0, 32'h0, 32'h0000_0099};
        idle();
        reset = 1'b1;
        repeat (2) next_cycle();
        n_total++;
        if ((busy_vec === 32'h0) && (stall_cnt === 32'h0) && (s_stall_cnt === 4'h0)) begin
            n_pass++;
        end else begin
            $display("FAIL reset_state: busy %h cnt %h scnt %h", busy_vec, stall_cnt, s_stall_cnt);
        end
        reset = 1'b0;
        expect_val("reset_busy", S_BUSY, 32'h0);
        expect_val("reset_cnt",  S_CNT,  32'h0);
        expect_val("idle_go",    S_GO,   32'h1);

        // 1: nearest forward wins; then EXE killed; r0 never forwards
        next_cycle(); idle();
        set_src(0, 5'd5, 32'h0000_aaaa); set_src(1, 5'd0, 32'h0000_bbbb);
        set_fwd(0, 5'd5, 32'h11, 1'b1); set_fwd(1, 5'd5, 32'h22, 1'b1); set_fwd(2, 5'd0, 32'h33, 1'b1);
        expect_val("t1_exe_wins", S_SRC0, 32'h11);
        expect_val("t1_r0_rf",    S_SRC1, 32'h0000_bbbb);
        expect_val("t1_go",       S_GO,   32'h1);
        next_cycle();
        fwd_valid[0] = 1'b0;
        expect_val("t1_mem_after_kill", S_SRC0, 32'h22);
        expect_val("t1_go2",            S_GO,   32'h1);

        // 2: load-use; nearest not-ok hit must stall even with ok data farther out
        next_cycle(); idle();
        set_src(1, 5'd7, 32'h0);
        set_fwd(0, 5'd7, 32'h77, 1'b0); set_fwd(1, 5'd7, 32'h55, 1'b1);
        expect_val("t2_loaduse_go",  S_GO,   32'h0);
        expect_val("t2_nearest_val", S_SRC1, 32'h77);
        expect_val("t2_cnt0",        S_CNT,  32'h0);
        next_cycle(); idle();
        set_src(1, 5'd7, 32'h0);
        set_fwd(1, 5'd7, 32'h1234, 1'b1);
        expect_val("t2_mem_val", S_SRC1, 32'h1234);
        expect_val("t2_go",      S_GO,   32'h1);
        expect_val("t2_cnt1",    S_CNT,  32'h1);
        next_cycle(); idle();
        set_fwd(0, 5'd7, 32'h77, 1'b0);
        expect_val("t2_novalid_go", S_GO,  32'h1);
        expect_val("t2_cnt_hold",   S_CNT, 32'h1);

        // 3: long op on r9 -> WAW, RAW stall, completion with WB bypass
        next_cycle(); idle();
        id_valid = 1'b1; dst_we = 1'b1; dst_addr = 5'd9; lat_issue = 1'b1;
        expect_val("t3_issue_busy", S_BUSY, 32'h0);
        expect_val("t3_issue_go",   S_GO,   32'h1);
        next_cycle(); idle();
        id_valid = 1'b1; dst_we = 1'b1; dst_addr = 5'd9;
        expect_val("t3_busy9",  S_BUSY, 32'h0000_0200);
        expect_val("t3_waw_go", S_GO,   32'h0);
        next_cycle(); idle();
        set_src(0, 5'd9, 32'h0);
        expect_val("t3_raw_go", S_GO,  32'h0);
        expect_val("t3_cnt2",   S_CNT, 32'h2);
        next_cycle();
        lat_done = 1'b1; lat_done_waddr = 5'd9;
        set_fwd(2, 5'd9, 32'h0000_dead, 1'b1);
        expect_val("t3_done_bubble", S_GO,   32'h0);
        expect_val("t3_done_val",    S_SRC0, 32'h0000_dead);
        next_cycle();
        lat_done = 1'b0;
        expect_val("t3_busy_clr", S_BUSY, 32'h0);
        expect_val("t3_go",       S_GO,   32'h1);
        expect_val("t3_val",      S_SRC0, 32'h0000_dead);
        expect_val("t3_cnt4",     S_CNT,  32'h4);

        // 4: set wins over clear; done on idle reg and issue to r0 are no-ops
        next_cycle(); idle();
        lat_issue = 1'b1; dst_addr = 5'd3; lat_done = 1'b1; lat_done_waddr = 5'd3;
        next_cycle(); idle();
        lat_done = 1'b1; lat_done_waddr = 5'd12;
        expect_val("t4_set_wins", S_BUSY, 32'h0000_0008);
        next_cycle(); idle();
        lat_done = 1'b1; lat_done_waddr = 5'd3;
        expect_val("t4_done_idle_reg", S_BUSY, 32'h0000_0008);
        next_cycle(); idle();
        lat_issue = 1'b1; dst_addr = 5'd0;
        expect_val("t4_clear3", S_BUSY, 32'h0);
        next_cycle(); idle();
        expect_val("t4_issue_r0", S_BUSY, 32'h0);

        // 5: flush clears busy but not the counter; reset mid-stall clears both
        next_cycle(); idle();
        lat_issue = 1'b1; dst_addr = 5'd4;
        next_cycle(); idle();
        lat_issue = 1'b1; dst_addr = 5'd6;
        expect_val("t5_busy4", S_BUSY, 32'h0000_0010);
        next_cycle(); idle();
        flush = 1'b1;
        expect_val("t5_busy46", S_BUSY, 32'h0000_0050);
        next_cycle(); idle();
        expect_val("t5_flush_busy", S_BUSY, 32'h0);
        expect_val("t5_flush_cnt",  S_CNT,  32'h4);
        next_cycle(); idle();
        set_src(0, 5'd8, 32'h0); set_fwd(0, 5'd8, 32'h88, 1'b0);
        lat_issue = 1'b1; dst_addr = 5'd10;
        expect_val("t5_stall_go", S_GO, 32'h0);
        next_cycle();
        lat_issue = 1'b0;
        expect_val("t5_cnt5",   S_CNT,  32'h5);
        expect_val("t5_busy10", S_BUSY, 32'h0000_0400);
        next_cycle();
        reset = 1'b1;
        expect_val("t5_cnt6", S_CNT, 32'h6);
        next_cycle();
        reset = 1'b0;
        expect_val("t5_rst_cnt",  S_CNT,  32'h0);
        expect_val("t5_rst_busy", S_BUSY, 32'h0);
        next_cycle();
        expect_val("t5_cnt_restart", S_CNT, 32'h1);

        // 6: 4-bit counter saturates and clears (it has counted since reset fell)
        next_cycle(); idle();
        expect_val("t6_sgo",   S_SGO,   32'h0);
        expect_val("t6_ssrc",  S_SSRC0, 32'h99);
        expect_val("t6_sbusy", S_SBUSY, 32'h0);
        repeat (20) next_cycle();
        expect_val("t6_sat", S_SCNT, 32'hf);
        next_cycle();
        s_cnt_clr = 1'b1;
        expect_val("t6_sat_hold", S_SCNT, 32'hf);
        next_cycle();
        s_cnt_clr = 1'b0;
        expect_val("t6_clr0", S_SCNT, 32'h0);
        next_cycle();
        expect_val("t6_then1", S_SCNT, 32'h1);

        @(negedge clk);
        #1;
        done_r = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
